lz77_job_scheduler: RTL and testbench

Sequences one shared LZ77 encoder datapath between two requesters. Each requester supplies a base address. The block round-robin arbitrates between them, holds the encoder in reset, and streams BLOCK_LEN characters from a shared 1-cycle-latency character memory into the encoder. It then forwards every emitted (offset, match_len, char_nxt) tuple, tagged with the owning requester, and signals completion or timeout.

---
 rtl/lz77_job_scheduler_if.sv | 61 ++++++
 rtl/lz77_job_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_lz77_job_scheduler.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lz77_job_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : lz77_job_scheduler_if
// Purpose  : Bundles every non-clock/reset signal of lz77_job_scheduler.
//            modport master : the scheduler. It drives grant/busy/done/err,
//                             the memory address, the encoder control and the
//                             forwarded tuple stream.
//            modport slave  : the environment. It drives requests, bases,
//                             memory read data and the encoder results.
// Ports    : req, base0, base1, grant, busy, done, err       (job side)
//            mem_addr, mem_rdata                             (char memory)
//            enc_rst, enc_chardata, enc_valid, enc_finish,
//            enc_offset, enc_match_len, enc_char_nxt         (encoder)
//            out_valid, out_tag, out_offset, out_match_len,
//            out_char_nxt, tuple_cnt                         (tuple stream)
// Revision : 1.0 - initial release
// ============================================================================
interface lz77_job_scheduler_if #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 14
);
  logic [1:0]        req;
  logic [ADDR_W-1:0] base0;
  logic [ADDR_W-1:0] base1;
  logic [1:0]        grant;
  logic              busy;
  logic [1:0]        done;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              enc_rst;
  logic [7:0]        enc_chardata;
  logic              enc_valid;
  logic              enc_finish;
  logic [4:0]        enc_offset;
  logic [4:0]        enc_match_len;
  logic [7:0]        enc_char_nxt;
  logic              out_valid;
  logic              out_tag;
  logic [4:0]        out_offset;
  logic [4:0]        out_match_len;
  logic [7:0]        out_char_nxt;
  logic [CNT_W-1:0]  tuple_cnt;

  modport master (
    input  req, base0, base1, mem_rdata,
           enc_valid, enc_finish, enc_offset, enc_match_len, enc_char_nxt,
    output grant, busy, done, err, mem_addr, enc_rst, enc_chardata,
           out_valid, out_tag, out_offset, out_match_len, out_char_nxt,
           tuple_cnt
  );

  modport slave (
    output req, base0, base1, mem_rdata,
           enc_valid, enc_finish, enc_offset, enc_match_len, enc_char_nxt,
    input  grant, busy, done, err, mem_addr, enc_rst, enc_chardata,
           out_valid, out_tag, out_offset, out_match_len, out_char_nxt,
           tuple_cnt
  );
endinterface
`default_nettype wire

// File: rtl/lz77_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lz77_job_scheduler
// Purpose  : Time-shares one LZ77 encoder between two requesters. It
//            arbitrates round-robin, streams BLOCK_LEN characters from a
//            1-cycle-latency memory into the encoder, forwards the emitted
//            tuples tagged with the owner, and pulses done (with err on
//            timeout).
// Ports    : clk   - clock
//            reset - asynchronous active-high reset
//            bus   - lz77_job_scheduler_if.master (job, memory, encoder and
//                    tuple-stream signals)
// Revision : 1.0 - initial release
// ============================================================================
module lz77_job_scheduler #(
  parameter int ADDR_W    = 16,
  parameter int BLOCK_LEN = 8192,
  parameter int TIMEOUT   = 262143,
  parameter int CNT_W     = 14
) (
  input  wire logic             clk,
  input  wire logic             reset,
  lz77_job_scheduler_if.master  bus
);

  localparam int LOAD_W = $clog2(BLOCK_LEN + 1);
  localparam int RUN_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_PRIME = 3'd2,
    S_LOAD  = 3'd3,
    S_RUN   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state_q,        state_d;
  logic              owner_q,        owner_d;
  logic              last_owner_q,   last_owner_d;
  logic [1:0]        grant_q,        grant_d;
  logic              busy_q,         busy_d;
  logic [1:0]        done_q,         done_d;
  logic              err_q,          err_d;
  logic [ADDR_W-1:0] mem_addr_q,     mem_addr_d;
  logic [7:0]        chardata_q,     chardata_d;
  logic              enc_rst_q,      enc_rst_d;
  logic              out_valid_q,    out_valid_d;
  logic              out_tag_q,      out_tag_d;
  logic [4:0]        out_offset_q,   out_offset_d;
  logic [4:0]        out_match_len_q, out_match_len_d;
  logic [7:0]        out_char_nxt_q, out_char_nxt_d;
  logic [CNT_W-1:0]  tuple_cnt_q,    tuple_cnt_d;
  logic [LOAD_W-1:0] load_cnt_q,     load_cnt_d;
  logic [RUN_W-1:0]  run_cnt_q,      run_cnt_d;

  logic              arb_sel;

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_owner_d    = last_owner_q;
    grant_d         = grant_q;
    busy_d          = busy_q;
    done_d          = 2'b00;
    err_d           = 1'b0;
    mem_addr_d      = mem_addr_q;
    chardata_d      = chardata_q;
    out_valid_d     = 1'b0;
    out_tag_d       = out_tag_q;
    out_offset_d    = out_offset_q;
    out_match_len_d = out_match_len_q;
    out_char_nxt_d  = out_char_nxt_q;
    tuple_cnt_d     = tuple_cnt_q;
    load_cnt_d      = load_cnt_q;
    run_cnt_d       = run_cnt_q;

    // A lone request wins outright; on a tie the requester that did not own
    // the previous job goes next.
    case (bus.req)
      2'b01:   arb_sel = 1'b0;
      2'b10:   arb_sel = 1'b1;
      default: arb_sel = ~last_owner_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (bus.req != 2'b00) state_d = S_ARB;
      end

      S_ARB: begin
        if (bus.req == 2'b00) begin
          // Request withdrawn before it could be granted.
          state_d = S_IDLE;
        end else begin
          owner_d     = arb_sel;
          grant_d     = arb_sel ? 2'b10 : 2'b01;
          busy_d      = 1'b1;
          tuple_cnt_d = '0;
          // The base is captured so that it is already on mem_addr during
          // the PRIME cycle; this is the only point where it is sampled.
          mem_addr_d  = arb_sel ? bus.base1 : bus.base0;
          state_d     = S_PRIME;
        end
      end

      S_PRIME: begin
        // The memory returns byte[base] next cycle. Move the address one
        // ahead so that LOAD cycle t reads base+t and presents base+t+1.
        mem_addr_d = mem_addr_q + 1'b1;
        load_cnt_d = '0;
        state_d    = S_LOAD;
      end

      S_LOAD: begin
        chardata_d = bus.mem_rdata;
        if (load_cnt_q == LOAD_W'(BLOCK_LEN - 1)) begin
          run_cnt_d = '0;
          state_d   = S_RUN;
        end else begin
          load_cnt_d = load_cnt_q + 1'b1;
          mem_addr_d = mem_addr_q + 1'b1;
        end
      end

      S_RUN: begin
        if (bus.enc_valid) begin
          out_valid_d     = 1'b1;
          out_tag_d       = owner_q;
          out_offset_d    = bus.enc_offset;
          out_match_len_d = bus.enc_match_len;
          out_char_nxt_d  = bus.enc_char_nxt;
          if (tuple_cnt_q != {CNT_W{1'b1}}) tuple_cnt_d = tuple_cnt_q + 1'b1;
        end
        // A finish flag takes priority over a timeout in the same cycle.
        if (bus.enc_finish) begin
          done_d  = grant_q;
          state_d = S_DONE;
        end else if (run_cnt_q == RUN_W'(TIMEOUT - 1)) begin
          done_d  = grant_q;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        last_owner_d = owner_q;
        grant_d      = 2'b00;
        busy_d       = 1'b0;
        state_d      = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // The encoder only runs while characters stream in and tuples come out.
    enc_rst_d = !((state_d == S_LOAD) || (state_d == S_RUN));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      owner_q         <= 1'b0;
      last_owner_q    <= 1'b1;
      grant_q         <= 2'b00;
      busy_q          <= 1'b0;
      done_q          <= 2'b00;
      err_q           <= 1'b0;
      mem_addr_q      <= '0;
      chardata_q      <= 8'h00;
      enc_rst_q       <= 1'b1;
      out_valid_q     <= 1'b0;
      out_tag_q       <= 1'b0;
      out_offset_q    <= 5'd0;
      out_match_len_q <= 5'd0;
      out_char_nxt_q  <= 8'h00;
      tuple_cnt_q     <= '0;
      load_cnt_q      <= '0;
      run_cnt_q       <= '0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      last_owner_q    <= last_owner_d;
      grant_q         <= grant_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      err_q           <= err_d;
      mem_addr_q      <= mem_addr_d;
      chardata_q      <= chardata_d;
      enc_rst_q       <= enc_rst_d;
      out_valid_q     <= out_valid_d;
      out_tag_q       <= out_tag_d;
      out_offset_q    <= out_offset_d;
      out_match_len_q <= out_match_len_d;
      out_char_nxt_q  <= out_char_nxt_d;
      tuple_cnt_q     <= tuple_cnt_d;
      load_cnt_q      <= load_cnt_d;
      run_cnt_q       <= run_cnt_d;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.enc_rst       = enc_rst_q;
  // During LOAD the memory byte goes straight to the encoder so cycle t
  // carries byte[base+t]; afterwards the last byte is held.
  assign bus.enc_chardata  = (state_q == S_LOAD) ? bus.mem_rdata : chardata_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_tag       = out_tag_q;
  assign bus.out_offset    = out_offset_q;
  assign bus.out_match_len = out_match_len_q;
  assign bus.out_char_nxt  = out_char_nxt_q;
  assign bus.tuple_cnt     = tuple_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_lz77_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_lz77_job_scheduler
// Purpose  : Self-checking bench for lz77_job_scheduler. It provides a
//            registered character memory (mem[k] = k[7:0]) and a scripted
//            encoder stub. Expected tuples are queued as they are driven and
//            compared when the scheduler forwards them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lz77_job_scheduler;

  localparam int ADDR_W    = 16;
  localparam int BLOCK_LEN = 8;
  localparam int TIMEOUT   = 20;
  localparam int CNT_W     = 14;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lz77_job_scheduler_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bif ();

  lz77_job_scheduler #(
    .ADDR_W    (ADDR_W),
    .BLOCK_LEN (BLOCK_LEN),
    .TIMEOUT   (TIMEOUT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  // 1-cycle-latency character memory
  always @(posedge clk) bif.mem_rdata <= bif.mem_addr[7:0];

  typedef struct packed {
    logic       tag;
    logic [4:0] off;
    logic [4:0] ml;
    logic [7:0] ch;
  } tup_t;

  tup_t       exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         m_last;
  bit         done_ok = 1'b0;
  logic [4:0] off_tab [4] = '{5'd5, 5'd0, 5'd2, 5'd17};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Tuple scoreboard and spurious-done watch
  always @(negedge clk) begin
    tup_t e;
    if (!reset && bif.out_valid) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_tag",       bif.out_tag,       e.tag);
        check("out_offset",    bif.out_offset,    e.off);
        check("out_match_len", bif.out_match_len, e.ml);
        check("out_char_nxt",  bif.out_char_nxt,  e.ch);
      end
    end
    if (!reset && bif.done != 2'b00 && !done_ok) check("spurious_done", bif.done, 0);
  end

  // One complete job. Called on a negedge; returns on the negedge of the
  // IDLE cycle after DONE.
  task automatic do_job(input logic [1:0] r, input int ntup, input bit fin,
                        input bit same, input bit drop, input int lat);
    bit          own;
    logic [1:0]  oh;
    logic [15:0] b, a;
    int          k, w;
    bit          lwf;
    tup_t        e;
    own = (r == 2'b01) ? 1'b0 : (r == 2'b10) ? 1'b1 : ~m_last;
    oh  = own ? 2'b10 : 2'b01;
    b   = own ? bif.base1 : bif.base0;
    bif.req = r;
    w = 0;
    while (bif.grant == 2'b00 && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (lat >= 0) check("grant_latency", w, lat);
    check("grant",        bif.grant,     oh);
    check("busy",         bif.busy,      1);
    check("tuple_cnt_0",  bif.tuple_cnt, 0);
    check("prime_addr",   bif.mem_addr,  b);
    check("prime_encrst", bif.enc_rst,   1);
    for (int t = 0; t < BLOCK_LEN; t++) begin
      @(negedge clk);
      a = b + 16'(t);
      check("load_encrst", bif.enc_rst,      0);
      check("load_char",   bif.enc_chardata, a[7:0]);
      check("load_addr",   bif.mem_addr,     16'(a + 16'd1));
      // A stray strobe while loading must be ignored.
      if (t == 2) begin
        bif.enc_valid  = 1'b1;
        bif.enc_offset = 5'd31;
      end
      if (t == 3) bif.enc_valid = 1'b0;
      if (drop && t == 1) bif.req = 2'b00;
    end
    @(negedge clk);
    done_ok = 1'b1;
    k = 0;
    a = b + 16'(BLOCK_LEN - 1);
    check("run_encrst", bif.enc_rst,      0);
    check("char_hold",  bif.enc_chardata, a[7:0]);
    for (int i = 0; i < ntup; i++) begin
      e.tag = own;
      e.off = off_tab[i];
      e.ml  = 5'(i + 3);
      e.ch  = 8'($urandom);
      bif.enc_valid     = 1'b1;
      bif.enc_offset    = e.off;
      bif.enc_match_len = e.ml;
      bif.enc_char_nxt  = e.ch;
      exp_q.push_back(e);
      lwf = fin && same && (i == ntup - 1);
      if (lwf) bif.enc_finish = 1'b1;
      @(negedge clk);
      k++;
      bif.enc_valid  = 1'b0;
      bif.enc_finish = 1'b0;
      if (!lwf) begin
        @(negedge clk);
        k++;
      end
    end
    if (fin && !(same && ntup > 0)) begin
      bif.enc_finish = 1'b1;
      @(negedge clk);
      k++;
      bif.enc_finish = 1'b0;
    end else if (!fin) begin
      while (k < TIMEOUT) begin
        if (k == TIMEOUT - 1) check("no_early_done", bif.done, 0);
        @(negedge clk);
        k++;
      end
    end
    check("done",          bif.done,      oh);
    check("err",           bif.err,       !fin);
    check("tuple_cnt_end", bif.tuple_cnt, ntup);
    check("done_encrst",   bif.enc_rst,   1);
    @(negedge clk);
    done_ok = 1'b0;
    check("idle_grant", bif.grant, 0);
    check("idle_busy",  bif.busy,  0);
    check("idle_done",  bif.done,  0);
    check("idle_err",   bif.err,   0);
    m_last = own;
  endtask

  initial begin
    int w;
    reset             = 1'b1;
    bif.req           = 2'b00;
    bif.base0         = 16'h0100;
    bif.base1         = 16'hFFFE;
    bif.enc_valid     = 1'b0;
    bif.enc_finish    = 1'b0;
    bif.enc_offset    = 5'd0;
    bif.enc_match_len = 5'd0;
    bif.enc_char_nxt  = 8'h00;
    m_last            = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_grant",     bif.grant,        0);
    check("rst_busy",      bif.busy,         0);
    check("rst_done",      bif.done,         0);
    check("rst_err",       bif.err,          0);
    check("rst_encrst",    bif.enc_rst,      1);
    check("rst_addr",      bif.mem_addr,     0);
    check("rst_char",      bif.enc_chardata, 0);
    check("rst_out_valid", bif.out_valid,    0);
    check("rst_tuple_cnt", bif.tuple_cnt,    0);
    reset = 1'b0;
    @(negedge clk);

    // Single job with three tuples; the request drops mid-load.
    do_job(2'b01, 3, 1'b1, 1'b0, 1'b1, 2);

    // Tie held high: owners alternate; owner 1 also exercises address wrap.
    for (int j = 0; j < 4; j++) do_job(2'b11, 1, 1'b1, j[0], 1'b0, -1);

    // Timeout with two tuples and no finish.
    do_job(2'b01, 2, 1'b0, 1'b0, 1'b0, -1);
    bif.req = 2'b00;
    @(negedge clk);

    // Reset in the middle of LOAD.
    bif.req = 2'b01;
    w = 0;
    while (bif.grant == 2'b00 && w < 10) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_grant",     bif.grant,     0);
    check("abort_busy",      bif.busy,      0);
    check("abort_encrst",    bif.enc_rst,   1);
    check("abort_addr",      bif.mem_addr,  0);
    check("abort_tuple_cnt", bif.tuple_cnt, 0);
    bif.req = 2'b00;
    @(negedge clk);
    reset  = 1'b0;
    m_last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", bif.done, 0);
    end

    // A tie after reset must go to requester 0 again.
    do_job(2'b11, 1, 1'b1, 1'b0, 1'b0, 2);
    bif.req = 2'b00;

    repeat (3) @(negedge clk);
    check("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule
`default_nettype wire
